// File: rtl/mips_hazard_unit.sv
// Decode-stage forwarding and stall controller for the pipelined MIPS core.
// Tracks in-flight register writers over FWD_DEPTH stages (slot 0 = EX),
// resolves rs/rt operands from the youngest matching writer, raises load-use
// and MUL/DIV stalls, and keeps a busy counter for the MUL/DIV unit.
module mips_hazard_unit #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned FWD_DEPTH = 3,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned MD_LAT    = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        dec_valid,
   input  logic                        flush,
   input  logic [REG_AW-1:0]           rs_addr,
   input  logic [REG_AW-1:0]           rt_addr,
   input  logic                        rs_used,
   input  logic                        rt_used,
   input  logic [REG_AW-1:0]           dest_addr,
   input  logic                        dest_we,
   input  logic                        is_load,
   input  logic                        is_md,
   input  logic                        reads_hilo,
   input  logic [DATA_W-1:0]           rs_rf_data,
   input  logic [DATA_W-1:0]           rt_rf_data,
   input  logic [FWD_DEPTH*DATA_W-1:0] stage_data,
   output logic [DATA_W-1:0]           rs_data,
   output logic [DATA_W-1:0]           rt_data,
   output logic                        stall,
   output logic                        md_busy
);

   localparam int unsigned MDC_W = $clog2(MD_LAT + 1);

   typedef struct packed {
      logic              haz;
      logic [DATA_W-1:0] data;
   } res_t;

   // Per-slot writer tracking
   logic [FWD_DEPTH-1:0] vld_q, vld_d;
   logic [FWD_DEPTH-1:0] we_q,  we_d;
   logic [FWD_DEPTH-1:0] ld_q,  ld_d;
   logic [REG_AW-1:0]    dest_q [FWD_DEPTH];
   logic [REG_AW-1:0]    dest_d [FWD_DEPTH];

   logic [MDC_W-1:0]     md_cnt_q, md_cnt_d;

   res_t rs_res, rt_res;
   logic md_haz;
   logic issue;
   logic md_issue;

   // Youngest matching slot wins: the scan stops at the first hit from slot 0.
   // A load hit before LOAD_LAT has no data yet, so it becomes a hazard.
   function automatic res_t resolve(input logic [REG_AW-1:0] src,
                                    input logic              used,
                                    input logic [DATA_W-1:0] rf);
      res_t r;
      logic found;
      r.haz  = 1'b0;
      r.data = rf;
      found  = 1'b0;
      for (int unsigned i = 0; i < FWD_DEPTH; i++) begin
         if (!found && vld_q[i] && we_q[i] && (dest_q[i] == src) &&
             (src != '0) && used) begin
            found = 1'b1;
            if (ld_q[i] && (i < LOAD_LAT))
               r.haz = 1'b1;
            else
               r.data = stage_data[i*DATA_W +: DATA_W];
         end
      end
      return r;
   endfunction

   // Operand resolution, hazard detection and stall generation
   always_comb begin
      rs_res   = resolve(rs_addr, rs_used, rs_rf_data);
      rt_res   = resolve(rt_addr, rt_used, rt_rf_data);
      md_busy  = (md_cnt_q != '0);
      md_haz   = dec_valid & (reads_hilo | is_md) & md_busy;
      stall    = dec_valid & ~flush & (rs_res.haz | rt_res.haz | md_haz);
      rs_data  = rs_res.data;
      rt_data  = rt_res.data;
      issue    = dec_valid & ~stall & ~flush;
      md_issue = issue & is_md;
   end

   // Next slot contents: decode enters slot 0, every entry moves one slot down
   always_comb begin
      vld_d     = '0;
      we_d      = '0;
      ld_d      = '0;
      for (int unsigned i = 0; i < FWD_DEPTH; i++) dest_d[i] = '0;
      vld_d[0]  = issue;
      we_d[0]   = issue & dest_we;
      ld_d[0]   = issue & is_load;
      dest_d[0] = issue ? dest_addr : '0;
      for (int unsigned i = 1; i < FWD_DEPTH; i++) begin
         vld_d[i]  = vld_q[i-1];
         we_d[i]   = we_q[i-1];
         ld_d[i]   = ld_q[i-1];
         dest_d[i] = dest_q[i-1];
      end
   end

   // MUL/DIV busy counter: reload on issue, otherwise count down to zero
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_issue)
         md_cnt_d = MDC_W'(MD_LAT);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - MDC_W'(1);
   end

   // Slot and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         we_q     <= '0;
         ld_q     <= '0;
         md_cnt_q <= '0;
         for (int unsigned i = 0; i < FWD_DEPTH; i++) dest_q[i] <= '0;
      end else begin
         vld_q    <= vld_d;
         we_q     <= we_d;
         ld_q     <= ld_d;
         md_cnt_q <= md_cnt_d;
         for (int unsigned i = 0; i < FWD_DEPTH; i++) dest_q[i] <= dest_d[i];
      end
   end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Scoreboard bench for mips_hazard_unit: the driver pushes hand-computed
// expectations per cycle, a monitor pops and compares them on the falling edge.
module tb_mips_hazard_unit;

   localparam logic [31:0] RF_RS = 32'hF00D_0001;
   localparam logic [31:0] RF_RT = 32'hF00D_0002;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_valid, flush, rs_used, rt_used, dest_we, is_load, is_md, reads_hilo;
   logic [4:0]  rs_addr, rt_addr, dest_addr;
   logic [31:0] rs_rf_data, rt_rf_data;
   logic [95:0] sd1;
   logic [127:0] sd2;
   logic [31:0] rs_data, rt_data, rs_data2, rt_data2;
   logic        stall, md_busy, stall2, md_busy2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      bit          c_rs, c_rt, c_st, c_bz, c_rt2, c_st2;
      logic [31:0] rs, rt, rt2;
      logic        st, bz, st2;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   mips_hazard_unit u_dut (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .flush(flush),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
      .dest_addr(dest_addr), .dest_we(dest_we), .is_load(is_load), .is_md(is_md),
      .reads_hilo(reads_hilo), .rs_rf_data(rs_rf_data), .rt_rf_data(rt_rf_data),
      .stage_data(sd1), .rs_data(rs_data), .rt_data(rt_data),
      .stall(stall), .md_busy(md_busy)
   );

   mips_hazard_unit #(.FWD_DEPTH(4), .LOAD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .flush(flush),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
      .dest_addr(dest_addr), .dest_we(dest_we), .is_load(is_load), .is_md(is_md),
      .reads_hilo(reads_hilo), .rs_rf_data(rs_rf_data), .rt_rf_data(rt_rf_data),
      .stage_data(sd2), .rs_data(rs_data2), .rt_data(rt_data2),
      .stall(stall2), .md_busy(md_busy2)
   );

   function automatic exp_t blank(input string n);
      exp_t e;
      e.name = n;
      e.c_rs = 0; e.c_rt = 0; e.c_st = 0; e.c_bz = 0; e.c_rt2 = 0; e.c_st2 = 0;
      e.rs = '0; e.rt = '0; e.rt2 = '0; e.st = 0; e.bz = 0; e.st2 = 0;
      return e;
   endfunction

   function automatic void push_all(input string n, input logic [31:0] rs,
                                    input logic [31:0] rt, input logic st, input logic bz);
      exp_t e = blank(n);
      e.c_rs = 1; e.rs = rs; e.c_rt = 1; e.rt = rt;
      e.c_st = 1; e.st = st; e.c_bz = 1; e.bz = bz;
      q.push_back(e);
   endfunction

   function automatic void push_st(input string n, input logic st, input logic bz);
      exp_t e = blank(n);
      e.c_st = 1; e.st = st; e.c_bz = 1; e.bz = bz;
      q.push_back(e);
   endfunction

   function automatic void push2(input string n, input bit c_rt2,
                                 input logic [31:0] rt2, input logic st2);
      exp_t e = blank(n);
      e.c_rt2 = c_rt2; e.rt2 = rt2; e.c_st2 = 1; e.st2 = st2;
      q.push_back(e);
   endfunction

   function automatic void cmp(input string n, input string f,
                               input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s.%s actual=0x%08h required=0x%08h @%0t", n, f, act, exp, $time);
      end
   endfunction

   // Monitor: compare everything the driver queued for the current cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            if (e.c_rs)  cmp(e.name, "rs_data",  rs_data,  e.rs);
            if (e.c_rt)  cmp(e.name, "rt_data",  rt_data,  e.rt);
            if (e.c_st)  cmp(e.name, "stall",    32'(stall),   32'(e.st));
            if (e.c_bz)  cmp(e.name, "md_busy",  32'(md_busy), 32'(e.bz));
            if (e.c_rt2) cmp(e.name, "rt_data2", rt_data2, e.rt2);
            if (e.c_st2) cmp(e.name, "stall2",   32'(stall2),  32'(e.st2));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired @%0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      dec_valid = 0; flush = 0; rs_used = 0; rt_used = 0; dest_we = 0;
      is_load = 0; is_md = 0; reads_hilo = 0;
      rs_addr = '0; rt_addr = '0; dest_addr = '0;
   endtask

   task automatic dec(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                      input logic rtu, input logic [4:0] dst, input logic we,
                      input logic ld, input logic md, input logic hilo);
      dec_valid = 1; flush = 0;
      rs_addr = rs; rs_used = rsu; rt_addr = rt; rt_used = rtu;
      dest_addr = dst; dest_we = we; is_load = ld; is_md = md; reads_hilo = hilo;
   endtask

   task automatic drain(input int n);
      idle_in();
      repeat (n) tick();
   endtask

   initial begin
      rst_n = 0;
      rs_rf_data = RF_RS;
      rt_rf_data = RF_RT;
      sd1 = {32'hC2, 32'hAB, 32'h11};
      sd2 = {32'h24, 32'h23, 32'h22, 32'h21};
      idle_in();

      // Reset state
      tick();
      dec(5'd3, 1, 5'd4, 1, 5'd3, 1, 0, 0, 1);
      push_all("reset", RF_RS, RF_RT, 0, 0);
      tick();
      rst_n = 1;
      idle_in();
      push_all("release", RF_RS, RF_RT, 0, 0);
      tick();

      // ALU back-to-back forwarding
      dec(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
      push_all("alu_issue", RF_RS, RF_RT, 0, 0);
      tick();
      dec(5'd3, 1, 5'd2, 1, 5'd8, 1, 0, 0, 0);
      push_all("alu_fwd", 32'h11, RF_RT, 0, 0);
      tick();
      dec(5'd3, 1, 5'd8, 1, 5'd9, 0, 0, 0, 0);
      push_all("alu_fwd2", 32'hAB, 32'h11, 0, 0);
      tick();
      dec(5'd3, 0, 5'd3, 1, 5'd9, 0, 0, 0, 0);
      push_all("unused_rs", RF_RS, 32'hC2, 0, 0);
      tick();
      drain(4);

      // Load-use: one stall with LOAD_LAT=1, two with LOAD_LAT=2
      dec(5'd29, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0);
      push_all("lw_issue", RF_RS, RF_RT, 0, 0);
      push2("lw_issue2", 1, RF_RT, 0);
      tick();
      dec(5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0);
      push_st("lu_stall", 1, 0);
      push2("lu2_stall_a", 0, '0, 1);
      tick();
      push_all("lu_fwd", RF_RS, 32'hAB, 0, 0);
      push2("lu2_stall_b", 0, '0, 1);
      tick();
      push_all("lu_repeat", RF_RS, 32'hC2, 0, 0);
      push2("lu2_fwd", 1, 32'h23, 0);
      tick();
      drain(5);

      // Youngest writer wins; $0 never forwards or stalls
      dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
      tick();
      idle_in();
      tick();
      dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0, 0);
      tick();
      sd1 = {32'h1, 32'hAB, 32'h2};
      dec(5'd7, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0);
      push_all("youngest", 32'h2, RF_RT, 0, 0);
      tick();
      sd1 = {32'h7, 32'h6, 32'h5};
      dec(5'd0, 1, 5'd7, 1, 5'd0, 0, 0, 0, 0);
      push_all("zero_reg", RF_RS, 32'h6, 0, 0);
      tick();
      dec(5'd7, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);
      push_all("older_slot", 32'h7, RF_RT, 0, 0);
      tick();
      dec(5'd0, 1, 5'd0, 1, 5'd1, 0, 0, 0, 0);
      push_all("load_zero", RF_RS, RF_RT, 0, 0);
      tick();
      drain(4);
      sd1 = {32'hC2, 32'hAB, 32'h11};

      // Flushed writer leaves no trace
      dec(5'd0, 0, 5'd0, 0, 5'd4, 1, 1, 0, 0);
      flush = 1;
      push_all("flush_issue", RF_RS, RF_RT, 0, 0);
      tick();
      dec(5'd4, 1, 5'd4, 1, 5'd10, 0, 0, 0, 0);
      push_all("flush_nofwd", RF_RS, RF_RT, 0, 0);
      tick();
      drain(4);

      // MUL/DIV: MFLO waits 32 cycles; a flush mid-stall drops stall only
      dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      push_all("md_issue", RF_RS, RF_RT, 0, 0);
      tick();
      for (int k = 1; k <= 33; k++) begin
         dec(5'd0, 0, 5'd0, 0, 5'd2, 1, 0, 0, 1);
         if (k == 5) begin
            flush = 1;
            push_st("md_flush", 0, 1);
         end else if (k <= 32) begin
            push_st($sformatf("md_wait%0d", k), 1, 1);
         end else begin
            push_st("md_done", 0, 0);
         end
         tick();
      end
      idle_in();
      push_st("md_after", 0, 0);
      tick();
      drain(4);

      // Reset while MD counter is 10 and a load sits in slot 1
      dec(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      tick();
      idle_in();
      repeat (20) tick();
      dec(5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0, 0);
      tick();
      dec(5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 1);
      push_st("pre_rst", 1, 1);
      push2("pre_rst2", 0, '0, 1);
      tick();
      rst_n = 0;
      push_all("rst_async", RF_RS, RF_RT, 0, 0);
      push2("rst_async2", 0, '0, 0);
      tick();
      push_all("rst_hold", RF_RS, RF_RT, 0, 0);
      tick();
      rst_n = 1;
      push_all("rst_rel", RF_RS, RF_RT, 0, 0);
      tick();
      push_all("post_rst", RF_RS, RF_RT, 0, 0);
      tick();
      idle_in();

      // Let the monitor empty the scoreboard, bounded
      for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
      if (q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
- Parametrised forwarding and stall controller for the decode stage of the pipelined MIPS core.
- Tracks in-flight register writers in an internal shift register of FWD_DEPTH slots, covering stages EX, MEM and WB by default.
- Selects forwarded operand data, raises load-use and multi-cycle-unit stalls, and tracks a busy counter for the MUL/DIV unit.
- Replaces the hard-wired single-stage forwarding and load-use check in decode with a general N-stage, configurable-latency scheme.

Parameters:
- DATA_W, 32, operand width.
- REG_AW, 5, register address width.
- FWD_DEPTH, 3, tracked stages after decode; slot 0 = EX, slot FWD_DEPTH-1 = WB.
- LOAD_LAT, 1, first slot index at which load data is valid; must be < FWD_DEPTH.
- MD_LAT, 32, MUL/DIV busy cycles after issue; must be >= 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a real instruction.
- flush  in  1  squash the decode instruction this cycle.
- rs_addr  in  REG_AW  decode source register rs.
- rt_addr  in  REG_AW  decode source register rt.
- rs_used  in  1  the decode instruction reads rs.
- rt_used  in  1  the decode instruction reads rt.
- dest_addr  in  REG_AW  decode destination register.
- dest_we  in  1  the decode instruction writes dest_addr.
- is_load  in  1  the decode instruction is a load.
- is_md  in  1  the decode instruction starts MUL/DIV.
- reads_hilo  in  1  the decode instruction is MFHI/MFLO.
- rs_rf_data  in  DATA_W  register-file read of rs.
- rt_rf_data  in  DATA_W  register-file read of rt.
- stage_data  in  FWD_DEPTH*DATA_W  result held in each slot's stage; slice i = [i*DATA_W +: DATA_W].
- rs_data  out  DATA_W  resolved rs operand.
- rt_data  out  DATA_W  resolved rt operand.
- stall  out  1  hold PC and decode; insert a bubble into EX.
- md_busy  out  1  MUL/DIV counter is non-zero.

Behaviour:
- Slot state per entry: valid, we, dest, is_load. All entries advance one slot every clk; the entry leaving the last slot is dropped.
- Slot 0 load: takes the decode fields when dec_valid & ~stall & ~flush. Otherwise slot 0 takes a bubble (valid=0).
- Match on slot i for source s: valid & we & dest==s & s!=0 & s_used.
- Resolution: the youngest (lowest i) matching slot wins; older matches are ignored.
  - Youngest match is a load with i < LOAD_LAT: raise a load-use hazard.
  - Otherwise forward stage_data slice i.
  - No match, or s==0: pass the *_rf_data input.
- Register $0 always yields rf data; it is never forwarded and never stalls.
- MUL/DIV counter md_cnt (clog2(MD_LAT+1) bits):
  - Loads MD_LAT when is_md issues (dec_valid & is_md & ~stall & ~flush).
  - Otherwise decrements while non-zero; saturates at 0.
  - md_busy = (md_cnt != 0).
- MD hazard: dec_valid & (reads_hilo | is_md) & md_busy.
- stall = dec_valid & ~flush & (load-use hazard on rs or rt | MD hazard). It is combinational from registered state and inputs.
- flush has priority over stall. A flush does not cancel an already-issued MUL/DIV (md_cnt keeps counting).
- Operand paths rs_data and rt_data are purely combinational, zero added latency.
- Reset (async, rst_n low):
  - All slots invalid; md_cnt = 0.
  - Outputs: stall=0, md_busy=0, rs_data=rs_rf_data, rt_data=rt_rf_data.
- Reset asserted mid-stall or mid-MUL/DIV: abandons all tracking immediately. The first cycle after release behaves as an empty pipeline.

Test Plan (defaults unless stated):
- ALU back-to-back: ADDU $3 then ADDU using $3 next cycle, stage_data[0]=0x11 -> rs_data=0x11, stall=0.
- Load-use: LW $5 then ADDU reading $5 as rt -> stall=1 for exactly 1 cycle. The next cycle forwards slice 1 (0xAB), stall=0. With LOAD_LAT=2, FWD_DEPTH=4 the stall lasts 2 cycles.
- Youngest wins: writes to $7 in slots 2 (0x1) and 0 (0x2) -> rs_data=0x2. A write to $0 in slot 0 with rs_addr=0 -> rs_data=rs_rf_data.
- MUL/DIV: MULT, then MFLO on the next instruction -> stall for 32 cycles; md_busy falls after the 32nd; the MFLO issues in cycle 33.
- Flush: dest_we to $4 with flush=1, then a reader of $4 -> no forward, no stall. A flush during an MD stall -> stall=0 that cycle, md_cnt unaffected.
- Reset mid-MD count (md_cnt=10) and mid load-use -> stall=0 and md_busy=0 asynchronously; no forwarding after release.
